fetch_unit: RTL and testbench

- Instruction fetch stage feeding decode, and ultimately branch_unit.
- Holds the PC and issues one-outstanding-request fetches to instruction memory (req/gnt, then rvalid).
- Buffers one fetched instruction for decode under a valid/ready handshake.
- Redirects to a new PC when the execute stage reports a taken branch/jump, discarding wrong-path instructions.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 53 +++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_unit and fetch_buffer.
package fetch_unit_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry instruction register between fetch and decode.
// Flush wins over load; load wins over consumption.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem request FSM,
// redirect handling with wrong-path discard, single-entry output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  branch_take_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
  output logic                  misalign_o
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
  logic                  disc_q, disc_d;
  logic                  mis_q, mis_d;
  logic                  buf_valid;
  logic                  can_issue;
  logic                  issue;
  logic                  load;
  logic [DATA_WIDTH-1:0] tgt_al;

  assign tgt_al      = {branch_target_i[DATA_WIDTH-1:2], 2'b00};
  assign can_issue   = !buf_valid || instr_ready_i;
  assign imem_req_o  = (state_q == FETCH_REQ) && can_issue;
  assign imem_addr_o = pc_q;
  assign issue       = imem_req_o && imem_gnt_i;
  assign misalign_o  = mis_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    disc_d  = disc_q;
    load    = 1'b0;
    mis_d   = branch_take_i && (branch_target_i[1:0] != 2'b00);
    unique case (state_q)
      FETCH_IDLE: begin
        if (en_i) state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (issue) begin
          ipc_d   = pc_q;
          disc_d  = branch_take_i;
          state_d = FETCH_WAIT;
        end else if (!en_i) begin
          state_d = FETCH_IDLE;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          load    = !disc_q && !branch_take_i;
          disc_d  = 1'b0;
          state_d = en_i ? FETCH_REQ : FETCH_IDLE;
          if (load) pc_d = ipc_q + DATA_WIDTH'(INSTR_BYTES);
        end else if (branch_take_i) begin
          disc_d = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
    // Redirect overrides any sequential PC update.
    if (branch_take_i) pc_d = tgt_al;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      disc_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      disc_q  <= disc_d;
      mis_q   <= mis_d;
    end
  end

  fetch_buffer u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .flush_i (branch_take_i),
    .ready_i (instr_ready_i),
    .instr_i (imem_rdata_i),
    .pc_i    (ipc_q),
    .valid_o (buf_valid),
    .instr_o (instr_o),
    .pc_o    (instr_pc_o)
  );

  assign instr_valid_o = buf_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model plus transaction-level
// reference of the expected fetch/deliver stream.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        req, gnt = 1'b0, rvalid = 1'b0;
  logic        take = 1'b0, ready = 1'b0, valid, mis;
  logic [31:0] addr, rdata = '0, tgt = '0, instr, ipc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .en_i            (en),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_gnt_i      (gnt),
    .imem_rvalid_i   (rvalid),
    .imem_rdata_i    (rdata),
    .branch_take_i   (take),
    .branch_target_i (tgt),
    .instr_valid_o   (valid),
    .instr_o         (instr),
    .instr_pc_o      (ipc),
    .instr_ready_i   (ready),
    .misalign_o      (mis)
  );

  int vecs = 0;
  int errs = 0;

  logic [31:0] m_pc, out_addr, exp_instr, exp_pc;
  bit          out_pend, out_stale, exp_valid, exp_mis;
  int          out_delay;
  int          p_gnt = 100, p_ready = 100, p_br = 0;
  int          lat_min = 0, lat_max = 0;
  int          trig_mode = 0;
  logic [31:0] trig_addr, trig_tgt;
  logic [31:0] iss_q[$];
  logic [31:0] dlv_q[$];
  int          mis_cnt = 0, load_cnt = 0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] iss_after(input logic [31:0] a);
    for (int i = 0; i + 1 < iss_q.size(); i++)
      if (iss_q[i] == a) return iss_q[i+1];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dlv(input int i);
    if (i < dlv_q.size()) return dlv_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC;
    out_pend = 0;
    out_stale = 0;
    out_delay = 0;
    exp_valid = 0;
    exp_mis = 0;
    exp_instr = '0;
    exp_pc = '0;
    iss_q.delete();
    dlv_q.delete();
    mis_cnt = 0;
    load_cnt = 0;
    trig_mode = 0;
  endtask

  // One clock: check outputs, drive memory/decode/branch, advance model.
  task automatic cycle();
    bit consumed, issue;
    @(negedge clk);
    chk("valid", 32'(valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("instr", instr, exp_instr);
      chk("instr_pc", ipc, exp_pc);
    end
    chk("misalign", 32'(mis), 32'(exp_mis));
    if (mis) mis_cnt++;
    ready = ($urandom_range(99) < p_ready);
    gnt = ($urandom_range(99) < p_gnt);
    rvalid = 1'b0;
    rdata = $urandom;
    if (out_pend && out_delay == 0) begin
      rvalid = 1'b1;
      rdata = hash(out_addr);
    end else if (!out_pend && $urandom_range(7) == 0) begin
      rvalid = 1'b1;
    end
    take = 1'b0;
    tgt = $urandom;
    if (p_br > 0 && $urandom_range(99) < p_br) begin
      take = 1'b1;
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
    end
    #1;
    issue = req && gnt;
    if ((trig_mode == 1 && issue && addr == trig_addr) ||
        (trig_mode == 2 && out_pend && !rvalid && out_addr == trig_addr)) begin
      take = 1'b1;
      tgt = trig_tgt;
      trig_mode = 0;
    end
    chk("addr_align", 32'(addr[1:0]), 32'd0);
    if (req) begin
      chk("req_while_full", 32'(exp_valid && !ready), 32'd0);
      chk("req_while_pending", 32'(out_pend), 32'd0);
      chk("req_addr", addr, m_pc);
    end
    consumed = exp_valid && ready;
    if (consumed) begin
      dlv_q.push_back(exp_pc);
      exp_valid = 0;
    end
    if (out_pend && rvalid) begin
      out_pend = 0;
      if (!out_stale && !take) begin
        exp_valid = 1;
        exp_instr = rdata;
        exp_pc = out_addr;
        m_pc = out_addr + 32'd4;
        load_cnt++;
      end
    end else if (out_pend) begin
      out_delay--;
    end
    if (take) begin
      exp_valid = 0;
      m_pc = {tgt[31:2], 2'b00};
      if (out_pend) out_stale = 1;
    end
    if (issue) begin
      iss_q.push_back(addr);
      out_pend = 1;
      out_addr = addr;
      out_stale = take;
      out_delay = int'($urandom_range(lat_max, lat_min));
    end
    exp_mis = take && (tgt[1:0] != 2'b00);
  endtask

  // Reset is asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, RPC);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", ipc, 32'd0);
    chk("rst_misalign", 32'(mis), 32'd0);
    en = 1'b0;
    gnt = 1'b0;
    rvalid = 1'b0;
    take = 1'b0;
    ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
  endtask

  task automatic set_mem(input int pg, input int pr, input int pb,
                         input int lmin, input int lmax);
    p_gnt = pg;
    p_ready = pr;
    p_br = pb;
    lat_min = lmin;
    lat_max = lmax;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();

    // Straight-line fetch 0x0, 0x4, 0x8
    set_mem(100, 100, 0, 0, 0);
    do_reset();
    cycle();
    chk("first_issue_cnt", 32'(iss_q.size()), 32'd1);
    chk("first_issue_addr", iss_q[0], RPC);
    repeat (9) cycle();
    chk("seq_iss1", iss_q[1], 32'h4);
    chk("seq_iss2", iss_q[2], 32'h8);
    chk("seq_dlv0", dlv(0), 32'h0);
    chk("seq_dlv1", dlv(1), 32'h4);
    chk("seq_dlv2", dlv(2), 32'h8);

    // Backpressure: buffer held, no new request
    set_mem(100, 0, 0, 0, 0);
    do_reset();
    repeat (7) cycle();
    chk("bp_issue_cnt", 32'(iss_q.size()), 32'd1);
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_instr", instr, hash(32'h0));
    p_ready = 100;
    repeat (8) cycle();
    chk("bp_dlv0", dlv(0), 32'h0);
    chk("bp_dlv1", dlv(1), 32'h4);

    // Redirect while waiting on 0x8
    set_mem(100, 100, 0, 2, 2);
    do_reset();
    trig_mode = 2;
    trig_addr = 32'h8;
    trig_tgt = 32'h100;
    repeat (25) cycle();
    chk("wait_br_fired", 32'(trig_mode), 32'd0);
    chk("wait_br_next_iss", iss_after(32'h8), 32'h100);
    chk("wait_br_dlv1", dlv(1), 32'h4);
    chk("wait_br_dlv2", dlv(2), 32'h100);

    // Redirect on the grant of 0x4
    set_mem(100, 100, 0, 0, 0);
    do_reset();
    trig_mode = 1;
    trig_addr = 32'h4;
    trig_tgt = 32'h40;
    repeat (15) cycle();
    chk("gnt_br_next_iss", iss_after(32'h4), 32'h40);
    chk("gnt_br_dlv1", dlv(1), 32'h40);

    // Misaligned target
    do_reset();
    trig_mode = 1;
    trig_addr = 32'h4;
    trig_tgt = 32'h102;
    repeat (15) cycle();
    chk("mis_next_iss", iss_after(32'h4), 32'h100);
    chk("mis_pulse_cnt", 32'(mis_cnt), 32'd1);
    chk("mis_dlv1", dlv(1), 32'h100);

    // PC wrap
    do_reset();
    trig_mode = 1;
    trig_addr = 32'h4;
    trig_tgt = 32'hFFFF_FFFC;
    repeat (15) cycle();
    chk("wrap_next_iss", iss_after(32'hFFFF_FFFC), 32'h0);
    chk("wrap_dlv1", dlv(1), 32'hFFFF_FFFC);
    chk("wrap_dlv2", dlv(2), 32'h0);

    // Async reset in the middle of an outstanding fetch of 0x4
    set_mem(100, 100, 0, 3, 3);
    do_reset();
    repeat (7) cycle();
    chk("mid_wait_addr", addr, 32'h4);
    do_reset();
    cycle();
    chk("post_rst_iss_cnt", 32'(iss_q.size()), 32'd1);
    chk("post_rst_iss", iss_q[0], RPC);

    // Enable dropped during WAIT: response kept, no further fetch
    do_reset();
    repeat (2) cycle();
    en = 1'b0;
    repeat (10) cycle();
    chk("en_off_iss_cnt", 32'(iss_q.size()), 32'd1);
    chk("en_off_loads", 32'(load_cnt), 32'd1);
    chk("en_off_dlv0", dlv(0), 32'h0);

    // Randomized traffic
    set_mem(60, 60, 4, 0, 3);
    do_reset();
    repeat (3000) cycle();
    chk("rand_progress", 32'(load_cnt > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
